scsu_ahb_host: RTL and testbench

Synthesizable AHB-lite master that issues single register reads and writes into the scsu AHB slave port (ahb_scsu_s_* / scsu_s_ahb_*). A local command/response interface carries each access. The block pipelines address and data phases, handles wait states and two-cycle error responses, and returns one response per command. It sits between an on-chip host or sequencer and the scsu, and replaces the behavioural AHB slave-port tasks in integrated builds.

---
 rtl/scsu_ahb_host.sv | 199 +++++++++++++++++++
 tb/tb_scsu_ahb_host.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scsu_ahb_host.sv
// AHB-lite master issuing single byte/halfword accesses to the scsu slave port from a command/response stream.
// Optional build macro SCSU_AHB_HOST_TIMEOUT_EN adds a wait-state watchdog (TIMEOUT_CYCLES).
module scsu_ahb_host #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic        cmd_size,
   input  logic [15:0] cmd_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_tmo,
   output logic        busy,
   output logic [1:0]  mhtrans,
   output logic [1:0]  mhsize,
   output logic        mhwrite,
   output logic [15:0] mhaddr,
   output logic [15:0] mhwdata,
   input  logic [15:0] shrdata,
   input  logic        shready,
   input  logic [1:0]  shresp
);

   typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_PIPE, ST_ERR} state_t;

   state_t      state_q, state_d;
   logic        ap_valid_q, ap_valid_d;
   logic        ap_write_q, ap_write_d;
   logic        ap_size_q, ap_size_d;
   logic        ap_mis_q, ap_mis_d;
   logic [15:0] ap_addr_q, ap_addr_d;
   logic [15:0] ap_wdata_q, ap_wdata_d;
   logic        dp_valid_q, dp_valid_d;
   logic        dp_write_q, dp_write_d;
   logic        dp_size_q, dp_size_d;
   logic        dp_mis_q, dp_mis_d;
   logic        dp_addr0_q, dp_addr0_d;
   logic [15:0] dp_wdata_q, dp_wdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [15:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic        rsp_tmo_q, rsp_tmo_d;

   logic adv, err_hold, ap_go, accept;
   logic dp_ok, dp_fail, ap_retire, ap_to_dp;
   logic tmo_hit;

   function automatic logic [15:0] lane_sel(input logic size, input logic addr0,
                                            input logic [15:0] data);
      if (size)
         return data;
      else if (addr0)
         return {8'h00, data[15:8]};
      else
         return {8'h00, data[7:0]};
   endfunction

`ifdef SCSU_AHB_HOST_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        stall;

   assign stall   = dp_valid_q & ~dp_mis_q & ~shready;
   assign tmo_hit = stall & (tmo_cnt_q == TMO_LAST);
   assign tmo_cnt_d = (stall & ~tmo_hit) ? tmo_cnt_q + 16'd1 : 16'd0;

   always_ff @(posedge clk) begin
      if (!rst)
         tmo_cnt_q <= 16'd0;
      else
         tmo_cnt_q <= tmo_cnt_d;
   end
`else
   localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
   assign tmo_hit = 1'b0;
`endif

   assign err_hold  = (state_q == ST_ERR);
   // A misaligned entry never occupies the bus, so it cannot stall the pipe.
   assign adv       = ~dp_valid_q | dp_mis_q | shready;
   assign ap_go     = adv & ~err_hold;
   assign cmd_ready = rst & ap_go;
   assign accept    = cmd_valid & cmd_ready;

   always_comb begin
      dp_ok     = dp_valid_q & ~dp_mis_q & shready & (shresp == 2'b00);
      dp_fail   = dp_valid_q & (dp_mis_q | (shready & (shresp != 2'b00)));
      ap_retire = ap_go & ap_valid_q & ap_mis_q & ~dp_valid_q;
      ap_to_dp  = ap_go & ap_valid_q & ~ap_retire;

      ap_valid_d = ap_go ? accept : ap_valid_q;
      ap_write_d = ap_write_q;
      ap_size_d  = ap_size_q;
      ap_mis_d   = ap_mis_q;
      ap_addr_d  = ap_addr_q;
      ap_wdata_d = ap_wdata_q;
      if (accept) begin
         ap_write_d = cmd_write;
         ap_size_d  = cmd_size;
         ap_mis_d   = cmd_size & cmd_addr[0];
         ap_addr_d  = cmd_addr;
         ap_wdata_d = cmd_wdata;
      end

      dp_valid_d = dp_valid_q;
      if (tmo_hit)
         dp_valid_d = 1'b0;
      else if (adv)
         dp_valid_d = ap_to_dp;
      dp_write_d = dp_write_q;
      dp_size_d  = dp_size_q;
      dp_mis_d   = dp_mis_q;
      dp_addr0_d = dp_addr0_q;
      dp_wdata_d = dp_wdata_q;
      if (ap_to_dp) begin
         dp_write_d = ap_write_q;
         dp_size_d  = ap_size_q;
         dp_mis_d   = ap_mis_q;
         dp_addr0_d = ap_addr_q[0];
         dp_wdata_d = ap_wdata_q;
      end

      rsp_valid_d = dp_ok | dp_fail | tmo_hit | ap_retire;
      rsp_err_d   = dp_fail | tmo_hit | ap_retire;
      rsp_tmo_d   = tmo_hit;
      rsp_rdata_d = (dp_ok & ~dp_write_q) ? lane_sel(dp_size_q, dp_addr0_q, shrdata) : 16'h0000;

      // First error cycle or watchdog abort parks the bus at IDLE until the data phase closes.
      if (tmo_hit | (dp_valid_q & ~dp_mis_q & ~shready & (shresp != 2'b00)))
         state_d = ST_ERR;
      else if (err_hold & ~adv)
         state_d = ST_ERR;
      else begin
         case ({ap_valid_d, dp_valid_d})
            2'b10:   state_d = ST_ADDR;
            2'b01:   state_d = ST_DATA;
            2'b11:   state_d = ST_PIPE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         ap_valid_q  <= 1'b0;
         ap_write_q  <= 1'b0;
         ap_size_q   <= 1'b1;
         ap_mis_q    <= 1'b0;
         ap_addr_q   <= 16'h0000;
         ap_wdata_q  <= 16'h0000;
         dp_valid_q  <= 1'b0;
         dp_write_q  <= 1'b0;
         dp_size_q   <= 1'b1;
         dp_mis_q    <= 1'b0;
         dp_addr0_q  <= 1'b0;
         dp_wdata_q  <= 16'h0000;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 16'h0000;
         rsp_err_q   <= 1'b0;
         rsp_tmo_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ap_valid_q  <= ap_valid_d;
         ap_write_q  <= ap_write_d;
         ap_size_q   <= ap_size_d;
         ap_mis_q    <= ap_mis_d;
         ap_addr_q   <= ap_addr_d;
         ap_wdata_q  <= ap_wdata_d;
         dp_valid_q  <= dp_valid_d;
         dp_write_q  <= dp_write_d;
         dp_size_q   <= dp_size_d;
         dp_mis_q    <= dp_mis_d;
         dp_addr0_q  <= dp_addr0_d;
         dp_wdata_q  <= dp_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         rsp_tmo_q   <= rsp_tmo_d;
      end
   end

   assign mhtrans   = (ap_valid_q & ~ap_mis_q & ~err_hold) ? 2'b10 : 2'b00;
   assign mhsize    = {1'b0, ap_size_q};
   assign mhwrite   = ap_write_q;
   assign mhaddr    = ap_addr_q;
   assign mhwdata   = dp_wdata_q;
   assign busy      = ap_valid_q | dp_valid_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_tmo   = rsp_tmo_q;

endmodule

// File: tb/tb_scsu_ahb_host.sv
// Bench for scsu_ahb_host: small AHB slave model with wait/error/stuck controls, response scoreboard.
module tb_scsu_ahb_host;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid, cmd_ready, cmd_write, cmd_size;
   logic [15:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_err, rsp_tmo, busy;
   logic [15:0] rsp_rdata;
   logic [1:0]  mhtrans, mhsize, shresp;
   logic        mhwrite, shready;
   logic [15:0] mhaddr, mhwdata, shrdata;

   int total = 0;
   int bad = 0;

   typedef struct packed {
      logic [15:0] rdata;
      logic        err;
      logic        tmo;
   } exp_t;
   exp_t expq[$];

   // slave controls
   logic [15:0] wait_addr, err_addr;
   int          wait_n;
   logic        stuck;

   scsu_ahb_host #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_tmo(rsp_tmo), .busy(busy),
      .mhtrans(mhtrans), .mhsize(mhsize), .mhwrite(mhwrite), .mhaddr(mhaddr),
      .mhwdata(mhwdata), .shrdata(shrdata), .shready(shready), .shresp(shresp)
   );

   always #5 clk = ~clk;

   // slave model
   logic [15:0] mem [0:15];
   logic        dph_act, dph_wr, dph_sz, err_mode, err_ph;
   logic [15:0] dph_addr;
   int          wcnt;

   assign shready = stuck ? 1'b0 : (!dph_act ? 1'b1 : (err_mode ? err_ph : (wcnt == 0)));
   assign shresp  = (dph_act && err_mode) ? 2'b01 : 2'b00;
   assign shrdata = (dph_act && !dph_wr) ? mem[dph_addr[4:1]] : 16'h0000;

   always @(posedge clk) begin
      if (!rst) begin
         dph_act  <= 1'b0;
         dph_wr   <= 1'b0;
         dph_sz   <= 1'b0;
         dph_addr <= 16'h0000;
         err_mode <= 1'b0;
         err_ph   <= 1'b0;
         wcnt     <= 0;
      end else if (shready) begin
         if (dph_act && dph_wr && !err_mode) begin
            if (dph_sz)
               mem[dph_addr[4:1]] <= mhwdata;
            else if (dph_addr[0])
               mem[dph_addr[4:1]][15:8] <= mhwdata[15:8];
            else
               mem[dph_addr[4:1]][7:0] <= mhwdata[7:0];
         end
         dph_act  <= (mhtrans == 2'b10);
         dph_addr <= mhaddr;
         dph_wr   <= mhwrite;
         dph_sz   <= mhsize[0];
         wcnt     <= (mhaddr == wait_addr) ? wait_n : 0;
         err_mode <= (mhaddr == err_addr);
         err_ph   <= 1'b0;
      end else if (dph_act) begin
         if (err_mode)
            err_ph <= 1'b1;
         else if (wcnt > 0)
            wcnt <= wcnt - 1;
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got rdata=%0h err=%0b tmo=%0b want none",
                     rsp_rdata, rsp_err, rsp_tmo);
         end else begin
            exp_t e;
            e = expq.pop_front();
            chk("rsp", {14'd0, rsp_rdata, rsp_err, rsp_tmo}, {14'd0, e});
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic w, input logic sz, input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] erd, input logic eerr, input logic etmo, input bit push,
                       output int stalls, output logic [15:0] held);
      bit done;
      done = 0;
      stalls = 0;
      held = 16'h0000;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_size  = sz;
      cmd_addr  = a;
      cmd_wdata = wd;
      while (!done) begin
         @(negedge clk);
         if (cmd_ready === 1'b1) done = 1;
         else begin
            stalls++;
            held = mhaddr;
            if (stalls > 60) begin
               total++;
               bad++;
               $display("FAIL accept_timeout: got no cmd_ready for addr %0h want accept", a);
               done = 1;
            end
         end
      end
      if (push) expq.push_back({erd, eerr, etmo});
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_mhtrans"}, 32'(mhtrans), 32'h0);
      chk({tag, "_mhsize"}, 32'(mhsize), 32'h1);
      chk({tag, "_mhwrite"}, 32'(mhwrite), 32'h0);
      chk({tag, "_mhaddr"}, 32'(mhaddr), 32'h0);
      chk({tag, "_mhwdata"}, 32'(mhwdata), 32'h0);
      chk({tag, "_rsp"}, {13'd0, rsp_valid, rsp_rdata, rsp_err, rsp_tmo}, 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h0);
   endtask

   initial begin
      int st;
      logic [15:0] hd;
      int k;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_size  = 1'b0;
      cmd_addr  = 16'h0000;
      cmd_wdata = 16'h0000;
      wait_addr = 16'hFFFF;
      err_addr  = 16'hFFFF;
      wait_n    = 0;
      stuck     = 1'b0;
      rst       = 1'b0;
      cyc(3);
      chk_reset("reset");
      rst = 1'b1;
      cyc(1);
      chk("ready_after_reset", 32'(cmd_ready), 32'h1);

      // halfword write, zero-wait timing
      send(1, 1, 16'h3002, 16'hA5A5, 16'h0, 0, 0, 1, st, hd);
      chk("w_mhtrans", 32'(mhtrans), 32'h2);
      chk("w_mhwrite", 32'(mhwrite), 32'h1);
      chk("w_mhaddr", 32'(mhaddr), 32'h3002);
      chk("w_mhsize", 32'(mhsize), 32'h1);
      cyc(1);
      chk("w_mhwdata", 32'(mhwdata), 32'hA5A5);
      chk("w_rsp_early", 32'(rsp_valid), 32'h0);
      cyc(1);
      chk("w_rsp_lat", {30'd0, rsp_valid, rsp_err}, 32'h2);

      // reads and byte lanes
      send(0, 1, 16'h3002, 16'h0, 16'hA5A5, 0, 0, 1, st, hd);
      send(0, 0, 16'h3003, 16'h0, 16'h00A5, 0, 0, 1, st, hd);
      cyc(4);

      // back-to-back writes, 2 wait states on the second
      wait_addr = 16'h3002;
      wait_n    = 2;
      send(1, 1, 16'h3000, 16'h1111, 16'h0, 0, 0, 1, st, hd);
      send(1, 1, 16'h3002, 16'h2222, 16'h0, 0, 0, 1, st, hd);
      send(1, 1, 16'h3004, 16'h3333, 16'h0, 0, 0, 1, st, hd);
      chk("b2b_w2_stalls", 32'(st), 32'd0);
      send(1, 1, 16'h3006, 16'h4444, 16'h0, 0, 0, 1, st, hd);
      chk("b2b_w3_stalls", 32'(st), 32'd2);
      chk("b2b_haddr_held", 32'(hd), 32'h3004);
      cyc(4);
      wait_addr = 16'hFFFF;
      send(0, 1, 16'h3004, 16'h0, 16'h3333, 0, 0, 1, st, hd);
      send(0, 1, 16'h3006, 16'h0, 16'h4444, 0, 0, 1, st, hd);
      send(0, 0, 16'h3002, 16'h0, 16'h0022, 0, 0, 1, st, hd);
      send(0, 0, 16'h3001, 16'h0, 16'h0011, 0, 0, 1, st, hd);
      cyc(4);

      // ERROR on a read with a write waiting in the address phase
      err_addr = 16'h3008;
      send(0, 1, 16'h3008, 16'h0, 16'h0, 1, 0, 1, st, hd);
      send(1, 1, 16'h300A, 16'h5A5A, 16'h0, 0, 0, 1, st, hd);
      cyc(1);
      chk("err_idle", 32'(mhtrans), 32'h0);
      chk("err_ready_low", 32'(cmd_ready), 32'h0);
      cyc(1);
      chk("err_rsp", {30'd0, rsp_valid, rsp_err}, 32'h3);
      chk("err_reissue", {14'd0, mhtrans, mhaddr}, {14'd0, 2'b10, 16'h300A});
      err_addr = 16'hFFFF;
      cyc(3);
      send(0, 1, 16'h300A, 16'h0, 16'h5A5A, 0, 0, 1, st, hd);
      cyc(4);

      // misaligned halfword
      send(1, 1, 16'h3001, 16'hBEEF, 16'h0, 1, 0, 1, st, hd);
      chk("mis_no_bus", 32'(mhtrans), 32'h0);
      cyc(1);
      chk("mis_rsp", {29'd0, rsp_valid, rsp_err, rsp_tmo}, 32'h6);
      chk("mis_no_bus2", 32'(mhtrans), 32'h0);
      send(1, 1, 16'h300C, 16'h7777, 16'h0, 0, 0, 1, st, hd);
      send(0, 1, 16'h300D, 16'h0, 16'h0, 1, 0, 1, st, hd);
      send(0, 1, 16'h300C, 16'h0, 16'h7777, 0, 0, 1, st, hd);
      send(0, 1, 16'h3000, 16'h0, 16'h1111, 0, 0, 1, st, hd);
      cyc(5);

`ifdef SCSU_AHB_HOST_TIMEOUT_EN
      stuck = 1'b1;
      send(0, 1, 16'h3000, 16'h0, 16'h0, 1, 1, 1, st, hd);
      k = 0;
      while (rsp_valid !== 1'b1 && k < 30) begin
         cyc(1);
         k++;
      end
      chk("tmo_latency", 32'(k), 32'd9);
      stuck = 1'b0;
      cyc(1);
      chk("tmo_idle", 32'(mhtrans), 32'h0);
      cyc(3);
`endif

      // reset in the middle of a stalled data phase
      stuck = 1'b1;
      send(0, 1, 16'h3000, 16'h0, 16'h0, 0, 0, 0, st, hd);
      cyc(3);
      chk("stall_busy", 32'(busy), 32'h1);
      rst = 1'b0;
      cyc(1);
      chk_reset("midrst");
      rst = 1'b1;
      stuck = 1'b0;
      cyc(2);
      send(1, 1, 16'h3010, 16'hC3C3, 16'h0, 0, 0, 1, st, hd);
      send(0, 1, 16'h3010, 16'h0, 16'hC3C3, 0, 0, 1, st, hd);

      k = 0;
      while (expq.size() != 0 && k < 100) begin
         cyc(1);
         k++;
      end
      chk("drain", 32'(expq.size()), 32'd0);
      cyc(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
